// File: rtl/snn_spike_encoder_if.sv
// Load/step handshake and spike-byte bus between the frame source, the encoder and the SNN core.
interface snn_spike_encoder_if #(
  parameter int unsigned IW = 4
);
  localparam int unsigned N_CH = 4;

  logic                   load;
  logic [N_CH*IW-1:0]     intensity_in;
  logic                   load_ready;
  logic                   step_en;
  logic                   abort;
  logic [2*IW-1:0]        ui_byte;
  logic [2*IW-1:0]        uio_byte;
  logic                   out_valid;
  logic                   frame_done;
  logic                   busy;

  modport master (
    output load, intensity_in, step_en, abort,
    input  load_ready, ui_byte, uio_byte, out_valid, frame_done, busy
  );

  modport slave (
    input  load, intensity_in, step_en, abort,
    output load_ready, ui_byte, uio_byte, out_valid, frame_done, busy
  );
endinterface

// File: rtl/snn_spike_encoder.sv
// Rate-coding spike encoder: a per-channel phase accumulator turns a captured 4-channel
// intensity frame into WINDOW spike timesteps, one per accepted step_en.
module snn_spike_encoder #(
  parameter int unsigned   IW        = 4,
  parameter int unsigned   WINDOW    = 16,
  parameter logic [IW-1:0] SPIKE_AMP = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  snn_spike_encoder_if.slave  bus
);
  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WINDOW - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [IW-1:0]    acc_q[N_CH];
  logic [IW-1:0]    acc_d[N_CH];
  logic [IW-1:0]    inten_q[N_CH];
  logic [IW-1:0]    inten_d[N_CH];
  logic [IW:0]      sum_c[N_CH];
  logic [IW-1:0]    nib_c[N_CH];
  logic [2*IW-1:0]  ui_q, ui_d, uio_q, uio_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             busy_q, ready_q;

  // State, accumulator and registered output bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      ui_q    <= '0;
      uio_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c]   <= '0;
        inten_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ui_q    <= ui_d;
      uio_q   <= uio_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= (state_d == RUN);
      ready_q <= (state_d == IDLE);
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c]   <= acc_d[c];
        inten_q[c] <= inten_d[c];
      end
    end
  end

  // Next-state, accumulator update and spike generation
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ui_d    = '0;
    uio_d   = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      acc_d[c]   = acc_q[c];
      inten_d[c] = inten_q[c];
      sum_c[c]   = {1'b0, acc_q[c]} + {1'b0, inten_q[c]};
      nib_c[c]   = sum_c[c][IW] ? SPIKE_AMP : '0;
    end

    if (bus.abort) begin
      state_d = IDLE;
      step_d  = '0;
      for (int c = 0; c < N_CH; c++) acc_d[c] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            state_d = RUN;
            step_d  = '0;
            for (int c = 0; c < N_CH; c++) begin
              acc_d[c]   = '0;
              inten_d[c] = bus.intensity_in[c*IW +: IW];
            end
          end
        end
        RUN: begin
          if (bus.step_en) begin
            for (int c = 0; c < N_CH; c++) acc_d[c] = sum_c[c][IW-1:0];
            ui_d    = {nib_c[0], nib_c[1]};
            uio_d   = {nib_c[2], nib_c[3]};
            valid_d = 1'b1;
            if (step_q == LAST_STEP) begin
              done_d  = 1'b1;
              state_d = IDLE;
              step_d  = '0;
            end else begin
              step_d = step_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.ui_byte    = ui_q;
  assign bus.uio_byte   = uio_q;
  assign bus.out_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = busy_q;
  assign bus.load_ready = ready_q;
endmodule

// File: tb/tb_snn_spike_encoder.sv
// Randomized scoreboard bench for snn_spike_encoder against a closed-form rate-coding model.
module tb_snn_spike_encoder;
  localparam int WINDOW = 16;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] uio;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_spike_encoder_if #(.IW(4)) bus ();

  snn_spike_encoder #(.IW(4), .WINDOW(WINDOW), .SPIKE_AMP(4'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   spk_cnt[4];

  // Reference model: frame state as plain integers
  bit   m_run = 1'b0;
  int   m_step = 0;
  int   m_i[4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // A channel of intensity I fires on step k when floor(k*I/WINDOW) advances.
  function automatic bit fires(input int inten, input int k);
    return ((k * inten) / WINDOW) != (((k - 1) * inten) / WINDOW);
  endfunction

  // One stimulus cycle: check status, apply inputs, advance the model
  task automatic drive(input bit ld, input logic [15:0] d, input bit st, input bit ab, input bit rs);
    exp_t e;
    int   k;
    logic [3:0] n[4];
    @(negedge clk);
    if (mon_en) begin
      chk("busy", int'(bus.busy), int'(m_run));
      chk("load_ready", int'(bus.load_ready), int'(!m_run));
    end
    rst              = rs;
    bus.load         = ld;
    bus.intensity_in = d;
    bus.step_en      = st;
    bus.abort        = ab;
    if (rs) begin
      m_run = 1'b0;
      for (int c = 0; c < 4; c++) m_i[c] = 0;
    end else if (ab) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (ld) begin
        m_run  = 1'b1;
        m_step = 0;
        for (int c = 0; c < 4; c++) m_i[c] = int'(d[4*c +: 4]);
      end
    end else if (st) begin
      m_step++;
      k = m_step;
      for (int c = 0; c < 4; c++) n[c] = fires(m_i[c], k) ? 4'd1 : 4'd0;
      e.ui   = {n[0], n[1]};
      e.uio  = {n[2], n[3]};
      e.done = (k == WINDOW);
      exp_q.push_back(e);
      if (k == WINDOW) m_run = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [15:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic steps(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  // Monitor: pop and compare on every out_valid, otherwise bytes must be quiet
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("ui_byte", int'(bus.ui_byte), int'(e.ui));
            chk("uio_byte", int'(bus.uio_byte), int'(e.uio));
            chk("frame_done", int'(bus.frame_done), int'(e.done));
            spk_cnt[0] += int'(bus.ui_byte[7:4] != 4'd0);
            spk_cnt[1] += int'(bus.ui_byte[3:0] != 4'd0);
            spk_cnt[2] += int'(bus.uio_byte[7:4] != 4'd0);
            spk_cnt[3] += int'(bus.uio_byte[3:0] != 4'd0);
          end
        end else begin
          chk("quiet_bytes", int'({bus.ui_byte, bus.uio_byte}), 0);
          chk("quiet_done", int'(bus.frame_done), 0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    rst = 1'b1;
    bus.load = 1'b0;
    bus.intensity_in = '0;
    bus.step_en = 1'b0;
    bus.abort = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;

    // Reset then idle
    idle(5);
    chk("reset_ui", int'(bus.ui_byte), 0);
    chk("reset_valid", int'(bus.out_valid), 0);

    // Half intensity, back-to-back
    load(16'h8888);
    steps(16, 0);
    idle(2);

    // Extremes: 15, 1, 0
    load(16'hF100);
    steps(16, 0);
    idle(2);

    // Random gaps with per-channel spike counts
    for (int c = 0; c < 4; c++) spk_cnt[c] = 0;
    load(16'h5A3C);
    steps(16, 3);
    idle(2);
    for (int c = 0; c < 4; c++) chk("spike_count", spk_cnt[c], int'(d_nib(16'h5A3C, c)));

    // Abort after step 7 with load in the same cycle, then replay
    load(16'h8888);
    steps(7, 0);
    drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    idle(2);
    load(16'h8888);
    steps(16, 0);

    // Load during RUN ignored; frame_done cycle accepts an immediate reload
    load(16'h3333);
    steps(5, 0);
    drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    steps(10, 0);
    load(16'h7E21);
    steps(8, 0);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    idle(3);
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_ready", int'(bus.load_ready), 1);

    // Step in IDLE ignored
    steps(3, 0);
    idle(2);

    // Random frames with occasional abort
    for (int f = 0; f < 8; f++) begin
      d = 16'($urandom);
      load(d);
      for (int s = 0; s < 16; s++) begin
        if ($urandom_range(0, 31) == 0) drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        else drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        idle(int'($urandom_range(0, 2)));
      end
      idle(2);
    end

    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic int d_nib(input logic [15:0] d, input int c);
    return int'(d[4*c +: 4]);
  endfunction
endmodule
